// File: rtl/uart_tx_word_arbiter.sv
// uart_tx_word_arbiter
// Round-robin arbiter that lets NUM_REQ 32-bit word sources share one uart_tx
// byte transmitter. The granted word goes out as 4 bytes, LSB first.
// Optional macro UART_ARB_HEADER_EN: prefix every frame with the header byte
// {5'b10100, grant_id}, giving 5-byte frames.
//
// state     | meaning
// IDLE      | no frame in flight; pick the next requester round-robin
// SEND      | wait for uart_tx to go idle, then strobe the current byte
// WAIT_DONE | wait for uart_tx byte-complete, bounded by TIMEOUT_CLKS
module uart_tx_word_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int CLKS_PER_BIT = 625,
    parameter int TIMEOUT_CLKS = 12 * CLKS_PER_BIT
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [32*NUM_REQ-1:0]  i_data,
    output logic [NUM_REQ-1:0]     o_ack,
    output logic [2:0]             o_grant_id,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_err,
    output logic                   o_txsenddata,
    output logic [7:0]             o_txbyte,
    input  logic                   i_txactive,
    input  logic                   i_txdone
);

    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
`ifdef UART_ARB_HEADER_EN
    localparam logic [2:0] LAST_BYTE = 3'd4;
`else
    localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [2:0]         ptr_q;
    logic [2:0]         byte_cnt_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [31:0]        word_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [2:0]         grant_id_q;
    logic               busy_q;
    logic               frame_done_q;
    logic               err_q;
    logic               txsend_q;
    logic [7:0]         txbyte_q;

    logic [2:0]         grant_d;
    logic               any_req_d;
    logic [7:0]         byte_d;

    // Round-robin search: first requester strictly after the pointer, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        grant_d   = ptr_q;
        any_req_d = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!any_req_d && i_req[idx]) begin
                any_req_d = 1'b1;
                grant_d   = 3'(idx);
            end
        end
    end

    // Byte to present for the current byte_cnt (header first when enabled).
    always_comb begin
        logic [1:0] sel;
`ifdef UART_ARB_HEADER_EN
        sel = 2'(byte_cnt_q - 3'd1);
        if (byte_cnt_q == 3'd0) begin
            byte_d = {5'b10100, grant_id_q};
        end else begin
            byte_d = word_q[{sel, 3'b000} +: 8];
        end
`else
        sel    = byte_cnt_q[1:0];
        byte_d = word_q[{sel, 3'b000} +: 8];
`endif
    end

    // Main FSM; all outputs are registered, pulses default low every cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            ptr_q        <= 3'(NUM_REQ - 1);
            byte_cnt_q   <= '0;
            tmo_q        <= '0;
            word_q       <= '0;
            ack_q        <= '0;
            grant_id_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            txsend_q     <= 1'b0;
            txbyte_q     <= '0;
        end else begin
            ack_q        <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            txsend_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        word_q     <= i_data[{grant_d, 5'b00000} +: 32];
                        grant_id_q <= grant_d;
                        ptr_q      <= grant_d;
                        ack_q      <= NUM_REQ'(1) << grant_d;
                        busy_q     <= 1'b1;
                        byte_cnt_q <= '0;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (!i_txactive) begin
                        txsend_q <= 1'b1;
                        txbyte_q <= byte_d;
                        tmo_q    <= '0;
                        state_q  <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (i_txdone) begin
                        if (byte_cnt_q == LAST_BYTE) begin
                            frame_done_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= IDLE;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                            state_q    <= SEND;
                        end
                    end else if (tmo_q == TMO_W'(TIMEOUT_CLKS)) begin
                        // Byte lost: abandon the whole frame, no retry.
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ack        = ack_q;
    assign o_grant_id   = grant_id_q;
    assign o_busy       = busy_q;
    assign o_frame_done = frame_done_q;
    assign o_err        = err_q;
    assign o_txsenddata = txsend_q;
    assign o_txbyte     = txbyte_q;

endmodule
